// File: rtl/sram_ctrl_if.sv
// Request/response handshake bundle for sram_ctrl.
interface sram_ctrl_if #(
    parameter int AW   = 1,
    parameter int COLS = 8
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic [COLS-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [COLS-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sram_ctrl.sv
// SRAM access sequencer: timed wordline pulses and sense-amp thresholding.
// Optional write read-back verify: define SRAM_CTRL_WR_VERIFY_EN.
module sram_ctrl #(
    parameter int  ROWS    = 2,
    parameter int  COLS    = 8,
    parameter int  AW      = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int  WR_CYC  = 10,
    parameter int  RD_CYC  = 10,
    parameter int  REC_CYC = 10,
    parameter real VDD     = 1.5,
    parameter real VSS     = 0.0,
    parameter real VTH     = 0.8
) (
    input  logic        clk,
    input  logic        rst_n,
    sram_ctrl_if.slave  bus,
    output real         row_wr  [0:ROWS-1],
    output real         row_rd  [0:ROWS-1],
    output real         data_in [0:COLS-1],
    input  real         preout  [0:COLS-1]
);
    localparam int MAXA = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
    localparam int MAXC = (MAXA > REC_CYC) ? MAXA : REC_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] WR_L  = CW'(WR_CYC - 1);
    localparam logic [CW-1:0] RD_L  = CW'(RD_CYC - 1);
    localparam logic [CW-1:0] REC_L = CW'(REC_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, WR_SETUP, WR_PULSE, WR_REC, RD_PULSE, RD_REC, RESP
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [AW-1:0]   addr_q;
    logic [COLS-1:0] wdata_q;
    logic [COLS-1:0] rdata_q;
    logic            err_q;
    logic [COLS-1:0] thr;
    logic            in_range;
    logic            err_n;
`ifdef SRAM_CTRL_WR_VERIFY_EN
    logic            we_q;
`endif

    assign in_range = int'(addr_q) < ROWS;

    always_comb begin
        thr = '0;
        for (int c = 0; c < COLS; c++)
            thr[c] = preout[c] > VTH;
    end

    always_comb begin
        err_n = !in_range;
`ifdef SRAM_CTRL_WR_VERIFY_EN
        if (we_q && thr != wdata_q)
            err_n = 1'b1;
`endif
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_n = bus.req_we ? WR_SETUP : RD_PULSE;
                    cnt_n   = bus.req_we ? '0 : RD_L;
                end
            end
            WR_SETUP: begin
                state_n = WR_PULSE;
                cnt_n   = WR_L;
            end
            WR_PULSE: begin
                if (cnt == '0) begin
                    state_n = WR_REC;
                    cnt_n   = REC_L;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            WR_REC: begin
                if (cnt == '0) begin
`ifdef SRAM_CTRL_WR_VERIFY_EN
                    state_n = RD_PULSE;
                    cnt_n   = RD_L;
`else
                    state_n = IDLE;
                    cnt_n   = '0;
`endif
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RD_PULSE: begin
                if (cnt == '0) begin
                    state_n = RD_REC;
                    cnt_n   = REC_L;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RD_REC: begin
                if (cnt == '0) begin
                    state_n = RESP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready)
                    state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef SRAM_CTRL_WR_VERIFY_EN
            we_q    <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && bus.req_valid) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
`ifdef SRAM_CTRL_WR_VERIFY_EN
                we_q    <= bus.req_we;
`endif
            end
            // sample on the edge that closes the last read-pulse cycle
            if (state == RD_PULSE && cnt == '0) begin
                rdata_q <= in_range ? thr : '0;
                err_q   <= err_n;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_wr[r] = (state == WR_PULSE && in_range &&
                         int'(addr_q) == r) ? VDD : VSS;
            row_rd[r] = (state == RD_PULSE && in_range &&
                         int'(addr_q) == r) ? VDD : VSS;
        end
    end

    always_comb begin
        for (int c = 0; c < COLS; c++)
            data_in[c] = ((state == WR_SETUP || state == WR_PULSE ||
                           state == WR_REC) && wdata_q[c]) ? VDD : VSS;
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a small behavioural cell-array model.
// Covers reset, write, read, threshold, out-of-range and verify builds.
module tb_sram_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_ctrl_if #(.AW(1), .COLS(8)) bus_a ();
    sram_ctrl_if #(.AW(2), .COLS(8)) bus_b ();

    real row_wr_a [0:1];
    real row_rd_a [0:1];
    real data_in_a [0:7];
    real preout_a [0:7];
    real row_wr_b [0:2];
    real row_rd_b [0:2];
    real data_in_b [0:7];
    real preout_b [0:7];

    sram_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .row_wr(row_wr_a), .row_rd(row_rd_a),
        .data_in(data_in_a), .preout(preout_a)
    );

    sram_ctrl #(.ROWS(3)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b),
        .row_wr(row_wr_b), .row_rd(row_rd_b),
        .data_in(data_in_b), .preout(preout_b)
    );

    logic [7:0] mem [0:1];
    logic       force_en = 1'b0;
    logic       stuck = 1'b0;
    real        force_v [0:7];

    always_ff @(posedge clk) begin
        for (int r = 0; r < 2; r++)
            if (row_wr_a[r] == 1.5)
                for (int c = 0; c < 8; c++)
                    mem[r][c] <= data_in_a[c] > 0.75;
    end

    always_comb begin
        for (int c = 0; c < 8; c++) begin
            preout_a[c] = 0.0;
            preout_b[c] = 1.5;
            if (force_en)
                preout_a[c] = force_v[c];
            else
                for (int r = 0; r < 2; r++)
                    if (row_rd_a[r] == 1.5 && mem[r][c])
                        preout_a[c] = 1.5;
            if (stuck && c == 0)
                preout_a[c] = 0.0;
        end
    end

    int checks = 0;
    int errors = 0;
    int n_wr0, n_wr1, n_rd0, n_rd1, n_rv, n_rr, n_olap, n_dbad;
    int n_bw, n_brv;
    logic       chk_d = 1'b0;
    logic [7:0] exp_d = 8'h00;
    logic [7:0] hold_d;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_r(input string tag, input real obs, input real exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_wr0 = 0; n_wr1 = 0; n_rd0 = 0; n_rd1 = 0; n_rv = 0;
        n_rr = 0; n_olap = 0; n_dbad = 0; n_bw = 0; n_brv = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (row_wr_a[0] == 1.5) n_wr0++;
            if (row_wr_a[1] == 1.5) n_wr1++;
            if (row_rd_a[0] == 1.5) n_rd0++;
            if (row_rd_a[1] == 1.5) n_rd1++;
            if ((row_wr_a[0] == 1.5 || row_wr_a[1] == 1.5) &&
                (row_rd_a[0] == 1.5 || row_rd_a[1] == 1.5)) n_olap++;
            if (chk_d)
                for (int c = 0; c < 8; c++)
                    if (data_in_a[c] != (exp_d[c] ? 1.5 : 0.0)) n_dbad++;
            if (bus_a.rsp_valid) n_rv++;
            if (bus_a.req_ready) n_rr++;
            for (int r = 0; r < 3; r++)
                if (row_wr_b[r] == 1.5 || row_rd_b[r] == 1.5) n_bw++;
            if (bus_b.rsp_valid) n_brv++;
            @(negedge clk);
        end
    endtask

    task automatic req_a(input logic we, input logic [0:0] addr,
                         input logic [7:0] d);
        bus_a.req_valid = 1'b1;
        bus_a.req_we    = we;
        bus_a.req_addr  = addr;
        bus_a.req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus_a.req_valid = 1'b0;
    endtask

    task automatic req_b(input logic we, input logic [1:0] addr,
                         input logic [7:0] d);
        bus_b.req_valid = 1'b1;
        bus_b.req_we    = we;
        bus_b.req_addr  = addr;
        bus_b.req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus_b.req_valid = 1'b0;
    endtask

    task automatic ack_a();
        bus_a.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.rsp_ready = 1'b0;
        chk("a_rsp_drop", 32'(bus_a.rsp_valid), 32'd0);
        chk("a_ready_back", 32'(bus_a.req_ready), 32'd1);
    endtask

    task automatic ack_b();
        bus_b.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_b.rsp_ready = 1'b0;
        chk("b_rsp_drop", 32'(bus_b.rsp_valid), 32'd0);
    endtask

    initial begin
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0;
        bus_a.req_addr = '0; bus_a.req_wdata = '0; bus_a.rsp_ready = 1'b0;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0;
        bus_b.req_addr = '0; bus_b.req_wdata = '0; bus_b.rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) force_v[c] = 0.0;
        #1;
        chk("rst_ready", 32'(bus_a.req_ready), 32'd1);
        chk("rst_valid", 32'(bus_a.rsp_valid), 32'd0);
        chk("rst_rdata", 32'(bus_a.rsp_rdata), 32'd0);
        chk("rst_err", 32'(bus_a.rsp_err), 32'd0);
        chk_r("rst_row_wr0", row_wr_a[0], 0.0);
        chk_r("rst_data_in0", data_in_a[0], 0.0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset in the third write-pulse cycle
        req_a(1'b1, 1'b0, 8'hFF);
        repeat (3) @(negedge clk);
        chk_r("mid_wr0_high", row_wr_a[0], 1.5);
        rst_n = 1'b0;
        #1;
        chk_r("mid_wr0_drop", row_wr_a[0], 0.0);
        chk("mid_ready", 32'(bus_a.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        run(45);
        chk("mid_no_rsp", 32'(n_rv), 32'd0);
        chk("mid_ready_rel", 32'(bus_a.req_ready), 32'd1);

        // write row 0
        exp_d = 8'b10110111;
        chk_d = 1'b1;
        req_a(1'b1, 1'b0, 8'b10110111);
        clr();
        run(21);
        chk_d = 1'b0;
        chk("wr_data_in", 32'(n_dbad), 32'd0);
        chk("wr_wr0_cycles", 32'(n_wr0), 32'd10);
        chk("wr_wr1_cycles", 32'(n_wr1), 32'd0);
        chk("wr_ready_busy", 32'(n_rr), 32'd0);
`ifdef SRAM_CTRL_WR_VERIFY_EN
        run(20);
        chk("wrv_valid", 32'(bus_a.rsp_valid), 32'd1);
        chk("wrv_rdata", 32'(bus_a.rsp_rdata), 32'hB7);
        chk("wrv_err", 32'(bus_a.rsp_err), 32'd0);
        ack_a();
`else
        chk("wr_ready_21", 32'(bus_a.req_ready), 32'd1);
`endif

        // read back row 0
        req_a(1'b0, 1'b0, 8'h00);
        clr();
        run(20);
        chk("rd_rd0_cycles", 32'(n_rd0), 32'd10);
        chk("rd_no_early", 32'(n_rv), 32'd0);
        chk("rd_olap", 32'(n_olap), 32'd0);
        chk("rd_valid_20", 32'(bus_a.rsp_valid), 32'd1);
        chk("rd_rdata", 32'(bus_a.rsp_rdata), 32'hB7);
        chk("rd_err", 32'(bus_a.rsp_err), 32'd0);
        hold_d = bus_a.rsp_rdata;
        clr();
        run(5);
        chk("rd_hold_valid", 32'(n_rv), 32'd5);
        chk("rd_hold_rdata", 32'(bus_a.rsp_rdata), 32'(hold_d));
        ack_a();

        // threshold boundary on row 1
        force_v[0] = 0.8;  force_v[1] = 0.81;
        force_v[2] = 0.0;  force_v[3] = 1.5;
        force_v[4] = 0.79; force_v[5] = 0.9;
        force_v[6] = 0.0;  force_v[7] = 1.5;
        force_en = 1'b1;
        req_a(1'b0, 1'b1, 8'h00);
        clr();
        run(20);
        force_en = 1'b0;
        chk("thr_rd1_cycles", 32'(n_rd1), 32'd10);
        chk("thr_valid", 32'(bus_a.rsp_valid), 32'd1);
        chk("thr_rdata", 32'(bus_a.rsp_rdata), 32'hAA);
        ack_a();

        // out-of-range read, ROWS=3
        req_b(1'b0, 2'd3, 8'h00);
        clr();
        run(20);
        chk("oor_rd_lines", 32'(n_bw), 32'd0);
        chk("oor_rd_valid", 32'(bus_b.rsp_valid), 32'd1);
        chk("oor_rd_rdata", 32'(bus_b.rsp_rdata), 32'd0);
        chk("oor_rd_err", 32'(bus_b.rsp_err), 32'd1);
        ack_b();

        // out-of-range write
        req_b(1'b1, 2'd3, 8'hFF);
        clr();
`ifdef SRAM_CTRL_WR_VERIFY_EN
        run(41);
        chk("oor_wr_lines", 32'(n_bw), 32'd0);
        chk("oor_wrv_valid", 32'(bus_b.rsp_valid), 32'd1);
        chk("oor_wrv_err", 32'(bus_b.rsp_err), 32'd1);
        ack_b();
`else
        run(21);
        chk("oor_wr_lines", 32'(n_bw), 32'd0);
        chk("oor_wr_no_rsp", 32'(n_brv), 32'd0);
        chk("oor_wr_ready", 32'(bus_b.req_ready), 32'd1);
`endif

`ifdef SRAM_CTRL_WR_VERIFY_EN
        // verify catches stuck-at-0 column 0
        stuck = 1'b1;
        req_a(1'b1, 1'b1, 8'hA5);
        clr();
        run(41);
        stuck = 1'b0;
        chk("ver_no_early", 32'(n_rv), 32'd0);
        chk("ver_valid", 32'(bus_a.rsp_valid), 32'd1);
        chk("ver_rdata", 32'(bus_a.rsp_rdata), 32'hA4);
        chk("ver_err", 32'(bus_a.rsp_err), 32'd1);
        ack_a();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Synchronous access sequencer sitting directly upstream of the write driver / cell array / sense amp chain. It accepts single-word read and write requests over a valid/ready handshake and converts them into timed real-valued wordline pulses (`row_wr`, `row_rd`) and data-line levels (`data_in`). It also thresholds the sense-amp `preout` levels back into a digital read word.

## Interface
Parameters:
- `ROWS`, 2, number of array rows.
- `COLS`, 8, word width / columns.
- `AW`, `$clog2(ROWS)` (minimum 1), address width.
- `WR_CYC`, 10, write-wordline pulse width in clocks (≥1).
- `RD_CYC`, 10, read-wordline pulse width in clocks (≥1).
- `REC_CYC`, 10, all-wordlines-low recovery after every pulse, in clocks (≥1).
- `VDD`, 1.5, real, logic-high drive level.
- `VSS`, 0.0, real, logic-low drive level.
- `VTH`, 0.8, real, read decision threshold.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in AW: row index.
- `req_wdata` in COLS: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out COLS: read word.
- `rsp_err` out 1: verify mismatch or address out of range.
- `row_wr` out real[0:ROWS-1]: write wordlines.
- `row_rd` out real[0:ROWS-1]: read wordlines.
- `data_in` out real[0:COLS-1]: write-driver inputs.
- `preout` in real[0:COLS-1]: sense-amp outputs.

## Operation
- FSM states: IDLE, WR_SETUP, WR_PULSE, WR_REC, RD_PULSE, RD_REC, RESP. Verify states are listed under Configuration.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch `req_we`, `req_addr` and `req_wdata`. Go to WR_SETUP if writing, RD_PULSE if reading.
- WR_SETUP lasts 1 cycle: `data_in[c]` = `wdata[c] ? VDD : VSS`. All wordlines stay at VSS.
- WR_PULSE lasts WR_CYC cycles: `row_wr[addr]`=VDD and `data_in` is held.
- WR_REC lasts REC_CYC cycles: all wordlines VSS, `data_in` held. Then go to IDLE; a plain write produces no response.
- RD_PULSE lasts RD_CYC cycles: `row_rd[addr]`=VDD and `data_in` is all VSS. On the clock edge ending the last pulse cycle, capture `rdata[c] = (preout[c] > VTH)`. A value exactly equal to VTH reads as 0.
- RD_REC lasts REC_CYC cycles: all wordlines VSS. Then go to RESP.
- RESP: `rsp_valid`=1, `rsp_rdata`/`rsp_err` are held stable. Leave for IDLE on the edge where `rsp_ready`=1.
- Outside the states above, every wordline and every `data_in` bit is VSS. At most one wordline is ever at VDD.
- Address ≥ ROWS:
  - No wordline asserts; the full state timing still elapses.
  - A write is dropped with no response.
  - A read responds with `rsp_rdata`=0 and `rsp_err`=1.
- Pulse-width counters count down from N-1 and exit at 0.

## Timing
- Reset values (asserted asynchronously, immediately): state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, all `row_wr`/`row_rd`/`data_in` = VSS, counters 0.
- Reset mid-pulse drops the wordline to VSS without waiting for a clock edge. The in-flight request is discarded.
- Write occupancy: acceptance edge, then 1 + WR_CYC + REC_CYC cycles until `req_ready` rises again. With defaults this is 21 cycles.
- Read latency: `rsp_valid` rises RD_CYC + REC_CYC cycles after the acceptance edge (20 with defaults). It stays high until `rsp_ready`.
- `req_ready` is low in every non-IDLE state. A request in the same cycle as `rsp_ready` in RESP is not accepted until the next cycle, when the FSM is back in IDLE.
- Consequences of REC_CYC ≥ 1:
  - `row_wr` and `row_rd` are never high in the same cycle.
  - Consecutive pulses are separated by ≥ REC_CYC low cycles.

## Configuration
- `SRAM_CTRL_WR_VERIFY_EN` defined:
  - After WR_REC, the FSM runs RD_PULSE/RD_REC on the same row.
  - It then enters RESP with `rsp_rdata` = read-back word and `rsp_err` = (read-back ≠ wdata) or address out of range.
  - Every write produces exactly one response. Write occupancy becomes 1 + WR_CYC + REC_CYC + RD_CYC + REC_CYC cycles before RESP.
- Not defined:
  - Writes produce no response.
  - `rsp_err` is asserted only for out-of-range reads.
  - The port list is identical in both builds.

## Test plan
- Reset mid-operation: assert `rst_n`=0 during WR_PULSE cycle 3 → `row_wr[0]` = 0.0 immediately, `req_ready`=1 after release, and no response is produced.
- Write: write row 0 with 8'b10110111 → `data_in` = {1.5,1.5,1.5,0.0,1.5,1.5,0.0,1.5} (bit 0 first) from the cycle after acceptance. `row_wr[0]`=1.5 for exactly 10 cycles, `row_wr[1]` = 0.0 throughout, and `req_ready` high again 21 cycles after acceptance.
- Read after write: read row 0 → `row_rd[0]`=1.5 for 10 cycles, then `rsp_valid` 20 cycles after acceptance with `rsp_rdata`=8'b10110111 and `rsp_err`=0. Hold `rsp_ready`=0 for 5 cycles → `rsp_rdata` stays stable.
- Threshold boundary: bench forces `preout` = {0.8, 0.81, …} → bit 0 = 0 and bit 1 = 1.
- Out-of-range: with ROWS=3, read address 3 → no wordline rises, `rsp_rdata`=0, `rsp_err`=1.
- Write verify (`SRAM_CTRL_WR_VERIFY_EN`): write 8'hA5 while the bench forces stuck-at-0 on column 0 → `rsp_valid` with `rsp_rdata`=8'hA4 and `rsp_err`=1.
